// File: rtl/segre_pkg.sv
// Shared types and sizes for the SEGRE data-cache port arbiter.
// Line alignment helper is used for refill addresses and drain-conflict detection.
package segre_pkg;

    localparam int ADDR_SIZE        = 32;
    localparam int DCACHE_BYTE_SIZE = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_SB   = 2'd2,
        SRC_MMU  = 2'd3
    } dcache_src_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        REPLAY    = 2'd3
    } dcache_arb_state_e;

    function automatic logic [ADDR_SIZE-1:0] line_align(input logic [ADDR_SIZE-1:0] addr);
        return {addr[ADDR_SIZE-1:DCACHE_BYTE_SIZE], {DCACHE_BYTE_SIZE{1'b0}}};
    endfunction

endpackage

// File: rtl/segre_starve_counter.sv
// Saturating wait counter for the store-buffer drain; sat_o flags that the
// drain has waited long enough to override a pipeline access.
module segre_starve_counter #(
    parameter int unsigned SB_STARVE_MAX = 8
) (
    input  logic clk_i,
    input  logic rsn_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CNT_W = $clog2(SB_STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_W'(SB_STARVE_MAX))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat_o = (cnt_q == CNT_W'(SB_STARVE_MAX));

endmodule

// File: rtl/segre_dcache_port_arbiter.sv
// Arbitrates the dcache data-array port between the memory stage, the store-buffer
// drain and MMU line fills, and sequences the miss/refill/replay handshake.
module segre_dcache_port_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned SB_STARVE_MAX = 8
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 pipe_req_i,
    input  logic                 pipe_is_ld_i,
    input  logic                 pipe_hit_i,
    input  logic [ADDR_SIZE-1:0] pipe_addr_i,
    output logic                 pipe_stall_o,
    input  logic                 sb_drain_req_i,
    input  logic [ADDR_SIZE-1:0] sb_drain_addr_i,
    output logic                 sb_drain_gnt_o,
    output logic                 mmu_req_o,
    output logic [ADDR_SIZE-1:0] mmu_addr_o,
    input  logic                 mmu_data_rdy_i,
    output logic                 dc_rd_o,
    output logic                 dc_wr_o,
    output logic                 dc_mmu_wr_o,
    output dcache_src_e          dc_sel_o
);

    dcache_arb_state_e    state_q, state_d;
    logic [ADDR_SIZE-1:0] mmu_addr_q, mmu_addr_d;
    logic                 mmu_req_q;

    logic stall, gnt, rd, wr, mmu_wr;
    dcache_src_e sel;
    logic starve_sat;
    logic drain_ok_miss;

    segre_starve_counter #(
        .SB_STARVE_MAX (SB_STARVE_MAX)
    ) u_starve (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .inc_i (sb_drain_req_i && !gnt),
        .clr_i (gnt || !sb_drain_req_i),
        .sat_o (starve_sat)
    );

    // A drain may slip in during a refill only if it cannot touch the line being filled.
    assign drain_ok_miss = sb_drain_req_i && !mmu_data_rdy_i &&
                           (line_align(sb_drain_addr_i) != mmu_addr_q);

    // NOTE: every signal gets a default first so the combinational block infers no latches.
    always_comb begin
        state_d    = state_q;
        mmu_addr_d = mmu_addr_q;
        stall      = 1'b0;
        gnt        = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        mmu_wr     = 1'b0;
        sel        = SRC_NONE;

        if (!rsn_i) begin
            unique case (state_q)
                IDLE: begin
                    if (pipe_req_i && starve_sat && sb_drain_req_i) begin
                        stall = 1'b1;
                        gnt   = 1'b1;
                        wr    = 1'b1;
                        sel   = SRC_SB;
                    end else if (pipe_req_i && pipe_hit_i) begin
                        rd  = pipe_is_ld_i;
                        wr  = !pipe_is_ld_i;
                        sel = SRC_PIPE;
                    end else if (pipe_req_i) begin
                        stall      = 1'b1;
                        mmu_addr_d = line_align(pipe_addr_i);
                        state_d    = MISS_REQ;
                    end else if (sb_drain_req_i) begin
                        gnt = 1'b1;
                        wr  = 1'b1;
                        sel = SRC_SB;
                    end
                end
                MISS_REQ, MISS_WAIT: begin
                    stall = 1'b1;
                    if (state_q == MISS_REQ) begin
                        state_d = MISS_WAIT;
                    end
                    if (state_q == MISS_WAIT && mmu_data_rdy_i) begin
                        mmu_wr  = 1'b1;
                        sel     = SRC_MMU;
                        state_d = REPLAY;
                    end else if (drain_ok_miss) begin
                        gnt = 1'b1;
                        wr  = 1'b1;
                        sel = SRC_SB;
                    end
                end
                REPLAY: begin
                    rd      = pipe_is_ld_i;
                    wr      = !pipe_is_ld_i;
                    sel     = SRC_PIPE;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q    <= IDLE;
            mmu_addr_q <= '0;
            mmu_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mmu_addr_q <= mmu_addr_d;
            mmu_req_q  <= (state_d == MISS_REQ);
        end
    end

    assign pipe_stall_o   = stall;
    assign sb_drain_gnt_o = gnt;
    assign dc_rd_o        = rd;
    assign dc_wr_o        = wr;
    assign dc_mmu_wr_o    = mmu_wr;
    assign dc_sel_o       = sel;
    assign mmu_req_o      = mmu_req_q;
    assign mmu_addr_o     = mmu_addr_q;

endmodule

// File: tb/tb_segre_dcache_port_arbiter.sv
// Directed bench for the dcache port arbiter: hits, miss sequencing, drains under
// a refill, MMU/drain collision, starvation override and reset mid-miss.
module tb_segre_dcache_port_arbiter;
    import segre_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rsn_i = 1'b1;
    logic                 pipe_req_i = 1'b0;
    logic                 pipe_is_ld_i = 1'b0;
    logic                 pipe_hit_i = 1'b0;
    logic [ADDR_SIZE-1:0] pipe_addr_i = '0;
    logic                 pipe_stall_o;
    logic                 sb_drain_req_i = 1'b0;
    logic [ADDR_SIZE-1:0] sb_drain_addr_i = '0;
    logic                 sb_drain_gnt_o;
    logic                 mmu_req_o;
    logic [ADDR_SIZE-1:0] mmu_addr_o;
    logic                 mmu_data_rdy_i = 1'b0;
    logic                 dc_rd_o, dc_wr_o, dc_mmu_wr_o;
    dcache_src_e          dc_sel_o;

    int checks = 0;
    int errors = 0;

    // Observed port bundle: {stall, gnt, rd, wr, mmu_wr, sel[1:0], mmu_req}
    logic [7:0] obs;
    logic [7:0] exp_v;
    assign obs = {pipe_stall_o, sb_drain_gnt_o, dc_rd_o, dc_wr_o, dc_mmu_wr_o, dc_sel_o, mmu_req_o};

    segre_dcache_port_arbiter #(.SB_STARVE_MAX(8)) dut (
        .clk_i           (clk_i),
        .rsn_i           (rsn_i),
        .pipe_req_i      (pipe_req_i),
        .pipe_is_ld_i    (pipe_is_ld_i),
        .pipe_hit_i      (pipe_hit_i),
        .pipe_addr_i     (pipe_addr_i),
        .pipe_stall_o    (pipe_stall_o),
        .sb_drain_req_i  (sb_drain_req_i),
        .sb_drain_addr_i (sb_drain_addr_i),
        .sb_drain_gnt_o  (sb_drain_gnt_o),
        .mmu_req_o       (mmu_req_o),
        .mmu_addr_o      (mmu_addr_o),
        .mmu_data_rdy_i  (mmu_data_rdy_i),
        .dc_rd_o         (dc_rd_o),
        .dc_wr_o         (dc_wr_o),
        .dc_mmu_wr_o     (dc_mmu_wr_o),
        .dc_sel_o        (dc_sel_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] ev(input logic stall, input logic gnt, input logic rd,
                                      input logic wr, input logic mw, input dcache_src_e sel,
                                      input logic req);
        return {stall, gnt, rd, wr, mw, sel, req};
    endfunction

    task automatic test_reset();
        @(negedge clk_i);
        rsn_i = 1'b1;
        pipe_req_i = 1'b1; pipe_is_ld_i = 1'b1; pipe_hit_i = 1'b1; pipe_addr_i = 32'h100;
        sb_drain_req_i = 1'b1; sb_drain_addr_i = 32'h2000; mmu_data_rdy_i = 1'b1;
        #1;
        exp_v = ev(0, 0, 0, 0, 0, SRC_NONE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", obs, exp_v);
        end
        checks++;
        if (mmu_addr_o !== 32'h0) begin
            errors++; $display("FAIL reset_mmu_addr: got %h want 00000000", mmu_addr_o);
        end
        @(negedge clk_i);
        rsn_i = 1'b0;
        pipe_req_i = 1'b0; sb_drain_req_i = 1'b0; mmu_data_rdy_i = 1'b0;
    endtask

    task automatic test_hit();
        @(negedge clk_i);
        pipe_req_i = 1'b1; pipe_is_ld_i = 1'b1; pipe_hit_i = 1'b1; pipe_addr_i = 32'h100;
        #1;
        exp_v = ev(0, 0, 1, 0, 0, SRC_PIPE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL load_hit: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        pipe_is_ld_i = 1'b0;
        #1;
        exp_v = ev(0, 0, 0, 1, 0, SRC_PIPE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL store_hit: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        pipe_req_i = 1'b0; sb_drain_req_i = 1'b1; sb_drain_addr_i = 32'h40;
        #1;
        exp_v = ev(0, 1, 0, 1, 0, SRC_SB, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL idle_drain: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        sb_drain_req_i = 1'b0; mmu_data_rdy_i = 1'b1;
        #1;
        exp_v = ev(0, 0, 0, 0, 0, SRC_NONE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL idle_rdy_ignored: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        mmu_data_rdy_i = 1'b0;
    endtask

    task automatic test_miss();
        int stalls = 0;
        int pulses = 0;
        @(negedge clk_i);
        pipe_req_i = 1'b1; pipe_is_ld_i = 1'b1; pipe_hit_i = 1'b0; pipe_addr_i = 32'h1234;
        #1;
        stalls += int'(pipe_stall_o); pulses += int'(mmu_req_o);
        exp_v = ev(1, 0, 0, 0, 0, SRC_NONE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL miss_detect: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        #1;
        stalls += int'(pipe_stall_o); pulses += int'(mmu_req_o);
        exp_v = ev(1, 0, 0, 0, 0, SRC_NONE, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL miss_req: got %b want %b", obs, exp_v);
        end
        checks++;
        if (mmu_addr_o !== 32'h1230) begin
            errors++; $display("FAIL miss_addr: got %h want 00001230", mmu_addr_o);
        end
        for (int w = 1; w <= 5; w++) begin
            @(negedge clk_i);
            mmu_data_rdy_i = (w == 5);
            #1;
            stalls += int'(pipe_stall_o); pulses += int'(mmu_req_o);
            exp_v = (w == 5) ? ev(1, 0, 0, 0, 1, SRC_MMU, 0) : ev(1, 0, 0, 0, 0, SRC_NONE, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL miss_wait_%0d: got %b want %b", w, obs, exp_v);
            end
        end
        @(negedge clk_i);
        mmu_data_rdy_i = 1'b0;
        #1;
        stalls += int'(pipe_stall_o); pulses += int'(mmu_req_o);
        exp_v = ev(0, 0, 1, 0, 0, SRC_PIPE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL miss_replay: got %b want %b", obs, exp_v);
        end
        checks++;
        if (stalls !== 7) begin
            errors++; $display("FAIL miss_stall_len: got %0d want 7", stalls);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL miss_req_pulses: got %0d want 1", pulses);
        end
        @(negedge clk_i);
        pipe_req_i = 1'b0;
    endtask

    task automatic test_drain_under_miss();
        @(negedge clk_i);
        pipe_req_i = 1'b1; pipe_is_ld_i = 1'b0; pipe_hit_i = 1'b0; pipe_addr_i = 32'h1234;
        sb_drain_req_i = 1'b1; sb_drain_addr_i = 32'h2000;
        #1;
        exp_v = ev(1, 0, 0, 0, 0, SRC_NONE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL dum_idle_miss: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        #1;
        exp_v = ev(1, 1, 0, 1, 0, SRC_SB, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL dum_miss_req_drain: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        #1;
        exp_v = ev(1, 1, 0, 1, 0, SRC_SB, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL dum_wait_drain: got %b want %b", obs, exp_v);
        end
        for (int w = 0; w < 2; w++) begin
            @(negedge clk_i);
            sb_drain_addr_i = 32'h1238;
            #1;
            exp_v = ev(1, 0, 0, 0, 0, SRC_NONE, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL dum_same_line_%0d: got %b want %b", w, obs, exp_v);
            end
        end
        @(negedge clk_i);
        sb_drain_addr_i = 32'h2000; mmu_data_rdy_i = 1'b1;
        #1;
        exp_v = ev(1, 0, 0, 0, 1, SRC_MMU, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL collision_mmu_wins: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        mmu_data_rdy_i = 1'b0; sb_drain_addr_i = 32'h1238;
        #1;
        exp_v = ev(0, 0, 0, 1, 0, SRC_PIPE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL dum_replay_store: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        pipe_req_i = 1'b0;
        #1;
        exp_v = ev(0, 1, 0, 1, 0, SRC_SB, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL dum_drain_after_idle: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        sb_drain_req_i = 1'b0;
    endtask

    task automatic test_starvation();
        @(negedge clk_i);
        pipe_req_i = 1'b1; pipe_is_ld_i = 1'b1; pipe_hit_i = 1'b1; pipe_addr_i = 32'h100;
        sb_drain_req_i = 1'b1; sb_drain_addr_i = 32'h3000;
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) @(negedge clk_i);
            #1;
            exp_v = (c == 9 || c == 18) ? ev(1, 1, 0, 1, 0, SRC_SB, 0)
                                        : ev(0, 0, 1, 0, 0, SRC_PIPE, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL starve_cycle_%0d: got %b want %b", c, obs, exp_v);
            end
        end
        @(negedge clk_i);
        pipe_req_i = 1'b0; sb_drain_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk_i);
        pipe_req_i = 1'b1; pipe_is_ld_i = 1'b1; pipe_hit_i = 1'b0; pipe_addr_i = 32'h5678;
        @(negedge clk_i);
        #1;
        checks++;
        if (mmu_addr_o !== 32'h5670) begin
            errors++; $display("FAIL rmm_addr: got %h want 00005670", mmu_addr_o);
        end
        @(negedge clk_i);
        rsn_i = 1'b1; mmu_data_rdy_i = 1'b1;
        #1;
        exp_v = ev(0, 0, 0, 0, 0, SRC_NONE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL rmm_in_reset: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        rsn_i = 1'b0; pipe_req_i = 1'b0;
        #1;
        exp_v = ev(0, 0, 0, 0, 0, SRC_NONE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL rmm_rdy_ignored: got %b want %b", obs, exp_v);
        end
        checks++;
        if (mmu_addr_o !== 32'h0) begin
            errors++; $display("FAIL rmm_addr_cleared: got %h want 00000000", mmu_addr_o);
        end
        @(negedge clk_i);
        mmu_data_rdy_i = 1'b0;
        pipe_req_i = 1'b1; pipe_hit_i = 1'b1; pipe_is_ld_i = 1'b1;
        #1;
        exp_v = ev(0, 0, 1, 0, 0, SRC_PIPE, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL rmm_hit_after: got %b want %b", obs, exp_v);
        end
        @(negedge clk_i);
        pipe_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_drain_under_miss();
        test_starvation();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/segre_dcache_port_arbiter.md
SEGRE_DCACHE_PORT_ARBITER -- requirements
Module: segre_dcache_port_arbiter

Interface
REQ-001 The module SHALL have parameter SB_STARVE_MAX, default 8: the number of cycles a pending store-buffer drain waits before it overrides a pipeline access.
REQ-002 clk_i  in  1  the single clock.
REQ-003 rsn_i  in  1  reset; synchronous, active-high (1 = reset).
REQ-004 pipe_req_i  in  1  memory-stage access valid (load or store).
REQ-005 pipe_is_ld_i  in  1  1 = load, 0 = store.
REQ-006 pipe_hit_i  in  1  dcache tag hit for pipe_addr_i, valid with pipe_req_i.
REQ-007 pipe_addr_i  in  ADDR_SIZE  access address.
REQ-008 pipe_stall_o  out  1  holds the pipeline (combinational).
REQ-009 sb_drain_req_i  in  1  store buffer has an entry to write.
REQ-010 sb_drain_addr_i  in  ADDR_SIZE  address of the head entry.
REQ-011 sb_drain_gnt_o  out  1  drain written this cycle (combinational).
REQ-012 mmu_req_o  out  1  line-fill request, one-cycle pulse.
REQ-013 mmu_addr_o  out  ADDR_SIZE  line-aligned miss address, registered.
REQ-014 mmu_data_rdy_i  in  1  fill line valid this cycle.
REQ-015 dc_rd_o, dc_wr_o, dc_mmu_wr_o  out  1 each  data-array strobes; at most one high per cycle.
REQ-016 dc_sel_o  out  dcache_src_e  data-array owner: SRC_NONE, SRC_PIPE, SRC_SB or SRC_MMU.

Function
REQ-017 The FSM SHALL have states IDLE, MISS_REQ, MISS_WAIT and REPLAY.
REQ-018 IDLE, with pipe_req_i=1, pipe_hit_i=1 and no starvation: grant SRC_PIPE in the same cycle, with dc_rd_o = pipe_is_ld_i and dc_wr_o = !pipe_is_ld_i, and no stall.
REQ-019 IDLE, with pipe_req_i=1 and pipe_hit_i=0:
- latch mmu_addr_o = pipe_addr_i with its low DCACHE_BYTE_SIZE bits zeroed;
- assert pipe_stall_o in the same cycle;
- go to MISS_REQ.
REQ-020 MISS_REQ: assert mmu_req_o for exactly one cycle and pipe_stall_o, then go to MISS_WAIT.
REQ-021 MISS_WAIT: hold pipe_stall_o=1. When mmu_data_rdy_i=1, drive dc_mmu_wr_o=1 and dc_sel_o=SRC_MMU in that cycle, then go to REPLAY.
REQ-022 REPLAY: grant SRC_PIPE for the held access (strobe per pipe_is_ld_i), deassert pipe_stall_o, then go to IDLE.
REQ-023 Miss latency: the stall SHALL be 3 cycles plus the MMU wait cycles (IDLE, MISS_REQ, MISS_WAIT...), and the access SHALL complete in REPLAY.
REQ-024 mmu_data_rdy_i SHALL have absolute priority over every other requester whenever the FSM is in MISS_WAIT.
REQ-025 mmu_data_rdy_i in any other state SHALL be ignored (no strobe).
REQ-026 A store-buffer drain SHALL be granted (SRC_SB, dc_wr_o=1) in either of these cases:
- in IDLE when pipe_req_i=0;
- in MISS_REQ or MISS_WAIT when mmu_data_rdy_i=0 and the line of sb_drain_addr_i differs from the line of mmu_addr_o.
REQ-027 A drain to the line under refill SHALL be blocked until the FSM returns to IDLE.
REQ-028 Starvation counter:
- increments each cycle that sb_drain_req_i=1 and sb_drain_gnt_o=0;
- saturates at SB_STARVE_MAX;
- clears on grant or when sb_drain_req_i=0.
REQ-029 In IDLE, with counter == SB_STARVE_MAX and pipe_req_i=1, the block SHALL grant SRC_SB and assert pipe_stall_o for that one cycle. Hit/miss evaluation of the pipeline access is deferred to the next cycle.
REQ-030 With no grant, dc_sel_o SHALL be SRC_NONE and all strobes 0.

Reset
REQ-031 With rsn_i=1 at a clock edge:
- state = IDLE;
- starvation counter = 0;
- mmu_addr_o = 0;
- mmu_req_o = 0.
REQ-032 During reset, all combinational outputs SHALL be 0 / SRC_NONE.
REQ-033 Reset mid-miss SHALL abandon the miss; a later mmu_data_rdy_i for it SHALL be ignored per REQ-025.

Structure
REQ-034 dcache_src_e and the FSM state enum SHALL live in segre_pkg, reusing ADDR_SIZE and DCACHE_BYTE_SIZE.
REQ-035 The starvation counter SHALL be a sub-module segre_starve_counter (inc, clr, sat output), parameterised by SB_STARVE_MAX.
REQ-036 The block SHALL sit beside segre_dcache_data and drive its rd/wr/mmu_wr strobes.

Verification
REQ-037 Hit: load hit at 0x100 in IDLE -> dc_rd_o=1, SRC_PIPE, pipe_stall_o=0, same cycle.
REQ-038 Miss: load miss at 0x1234 with MMU response 5 cycles after mmu_req_o -> mmu_addr_o=0x1230 (DCACHE_BYTE_SIZE=4), a single mmu_req_o pulse, then dc_mmu_wr_o, then REPLAY dc_rd_o; stall lasts 7 cycles.
REQ-039 Drain under miss: miss line 0x1230 with sb_drain_addr_i=0x2000 -> drain granted in MISS_WAIT; sb_drain_addr_i=0x1238 -> no grant until IDLE.
REQ-040 Starvation: continuous pipeline hits plus sb_drain_req_i=1 -> SRC_SB granted on the 9th cycle with a 1-cycle stall, then the counter reads 0.
REQ-041 Collision: mmu_data_rdy_i=1 with an eligible drain in MISS_WAIT -> SRC_MMU, sb_drain_gnt_o=0.
REQ-042 Reset: rsn_i asserted in MISS_WAIT, then mmu_data_rdy_i=1 -> IDLE, no dc_mmu_wr_o.
